// File: rtl/fifo.sv
// Purpose : single-clock synchronous FIFO, DEPTH x WIDTH, registered read data.
// Latency : an accepted read presents the word on code one edge later; flags update with count.
// Backpr. : writes while full are dropped unless a read happens in the same cycle; reads while empty are ignored.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      synchronous active-high reset
//   data       write data, captured when a write is accepted
//   wr_enable  write request, one word per cycle while high
//   rd_enable  read request, one word per cycle while high
//   code       registered read data, holds the last word read
//   full       registered, high when DEPTH words are stored
//   empty      registered, high when no words are stored
module fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             wr_enable,
    input  logic             rd_enable,
    output logic [WIDTH-1:0] code,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             rd_acc;
    logic             wr_acc;

    // A read while full frees a slot at the same edge, so the write is taken too.
    assign rd_acc = rd_enable && !empty;
    assign wr_acc = wr_enable && (!full || rd_enable);

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + (AW + 1)'(1);
            2'b01:   count_nxt = count - (AW + 1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is not cleared by reset; stale entries are unreachable because
    // the pointers and count restart from zero.
    always_ff @(posedge clock) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            code   <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                code   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Purpose : self-checking bench for fifo (WIDTH=4, DEPTH=16).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : directed vector table first, then a queue-based scoreboard phase.
module tb_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data;
    logic             wr_enable;
    logic             rd_enable;
    logic [WIDTH-1:0] code;
    logic             full;
    logic             empty;

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .wr_enable (wr_enable),
        .rd_enable (rd_enable),
        .code      (code),
        .full      (full),
        .empty     (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit               rst;
        bit               wr;
        bit               rd;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e_code;
        bit               e_full;
        bit               e_empty;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] last_code;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input bit rst, input bit wr, input bit rd, input int d,
                                input int e_code, input bit e_full, input bit e_empty);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.d = WIDTH'(d);
        v.e_code = WIDTH'(e_code); v.e_full = e_full; v.e_empty = e_empty;
        vecs.push_back(v);
    endfunction

    // Scoreboard cycle: the expected word is queued when a write is driven and
    // popped when the read it answers is driven; compared after the edge.
    task automatic sb_cycle(input bit wr, input bit rd, input logic [WIDTH-1:0] d);
        bit racc;
        bit wacc;
        racc = rd && (sb.size() > 0);
        wacc = wr && ((sb.size() < DEPTH) || rd);
        if (racc) last_code = sb.pop_front();
        if (wacc) sb.push_back(d);
        wr_enable = wr;
        rd_enable = rd;
        data      = d;
        @(posedge clock);
        #1;
        check("sb_code",  32'(code),  32'(last_code));
        check("sb_full",  32'(full),  32'(sb.size() == DEPTH));
        check("sb_empty", 32'(empty), 32'(sb.size() == 0));
        wr_enable = 1'b0;
        rd_enable = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0; data = '0;

        // Reset for two cycles, reads/writes requested but ignored.
        add(1, 1, 1, 9, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        // Fill with 0..F; full only after the 16th edge.
        for (int i = 0; i < DEPTH; i++) add(0, 1, 0, i, 0, (i == DEPTH - 1), 0);
        // 17th write dropped.
        add(0, 1, 0, 0, 0, 1, 0);
        // Drain: code follows write order, empty after 16th read.
        for (int i = 0; i < DEPTH; i++) add(0, 0, 1, 0, i, 0, (i == DEPTH - 1));
        // Reads while empty leave code at F.
        add(0, 0, 1, 0, 15, 0, 1);
        add(0, 0, 1, 0, 15, 0, 1);
        // Read+write while empty: only write taken, code unchanged.
        add(0, 1, 1, 5, 15, 0, 0);
        // Then read only: 5 appears, empty again.
        add(0, 0, 1, 0, 5, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            wr_enable = vecs[i].wr;
            rd_enable = vecs[i].rd;
            data      = vecs[i].d;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_code", i),  32'(code),  32'(vecs[i].e_code));
            check($sformatf("vec%0d_full", i),  32'(full),  32'(vecs[i].e_full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
        end
        reset = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
        last_code = 4'h5;

        // Interleaved random traffic; more writes than reads so the FIFO
        // fills, wraps and hits the full boundary.
        for (int i = 0; i < 300; i++) begin
            sb_cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                     WIDTH'($urandom_range(0, 15)));
        end
        guard = 0;
        while (sb.size() > 0 && guard < 4 * DEPTH) begin
            sb_cycle(1'b0, 1'b1, '0);
            guard++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);

        // Fill to full, then simultaneous read/write: full stays, oldest out.
        for (int i = 0; i < DEPTH; i++) sb_cycle(1'b1, 1'b0, WIDTH'(i + 3));
        sb_cycle(1'b1, 1'b1, 4'hA);
        check("full_rw_code", 32'(code), 32'h3);
        check("full_rw_full", 32'(full), 32'd1);
        sb_cycle(1'b1, 1'b1, 4'hB);
        guard = 0;
        while (sb.size() > 0 && guard < 4 * DEPTH) begin
            sb_cycle(1'b0, 1'b1, '0);
            guard++;
        end
        check("drain2_done", 32'(sb.size()), 32'd0);
        check("wrap_last", 32'(code), 32'hB);

        // Reset with 8 words stored takes priority over read/write.
        for (int i = 0; i < 8; i++) sb_cycle(1'b1, 1'b0, WIDTH'(i + 8));
        reset = 1'b1; wr_enable = 1'b1; rd_enable = 1'b1; data = 4'h7;
        @(posedge clock);
        #1;
        check("rst8_code",  32'(code),  32'h0);
        check("rst8_empty", 32'(empty), 32'd1);
        check("rst8_full",  32'(full),  32'd0);
        reset = 1'b0; wr_enable = 1'b0;
        sb.delete();
        last_code = '0;
        sb_cycle(1'b0, 1'b1, '0);
        sb_cycle(1'b0, 1'b1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
